// File: rtl/regfile_rst_if.sv
// Register-file bus: two combinational read ports, one write port and the
// written-since-reset flags and accepted-write counter the file reports back.
interface regfile_rst_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
);
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic             RegWrite;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic             ReadValid1;
  logic             ReadValid2;
  logic [CNTW-1:0]  WriteCount;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    input  ReadData1, ReadData2, ReadValid1, ReadValid2, WriteCount
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    output ReadData1, ReadData2, ReadValid1, ReadValid2, WriteCount
  );
endinterface

// File: rtl/regfile_rst.sv
// 32 x WIDTH register file, r0 reads as zero; synchronous reset, per-register
// written-since-reset flags, optional write-to-read bypass, accepted-write counter.
module regfile_rst #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 0,
  parameter int CNTW   = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  regfile_rst_if.slave bus
);

  localparam bit BypassEn = (BYPASS != 32'sd0);

  logic [WIDTH-1:0] regs_r [1:31];
  logic [31:1]      valid_r;
  logic [CNTW-1:0]  cnt_r;
  logic [31:1]      wr_sel_s;
  logic [WIDTH-1:0] rd1_s;
  logic [WIDTH-1:0] rd2_s;
  logic             rv1_s;
  logic             rv2_s;

  // One-hot write decode; reset and r0 both suppress the select, so the
  // same vector drives the update, the counter and the bypass match.
  always_comb begin
    wr_sel_s = '0;
    if (bus.RegWrite && !Reset && (bus.WriteRegister != 5'd0)) begin
      wr_sel_s[bus.WriteRegister] = 1'b1;
    end else begin
      wr_sel_s = '0;
    end
  end

  // Register array, written flags and accepted-write counter (wraps freely).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_r[i] <= '0;
      end
      valid_r <= '0;
      cnt_r   <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_sel_s[i]) begin
          regs_r[i] <= bus.WriteData;
        end
      end
      valid_r <= valid_r | wr_sel_s;
      if (|wr_sel_s) begin
        cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Read port 1: r0 constant, then bypass of a live write, then storage.
  always_comb begin
    rd1_s = '0;
    rv1_s = 1'b1;
    if (bus.ReadRegister1 == 5'd0) begin
      rd1_s = '0;
      rv1_s = 1'b1;
    end else if (BypassEn && wr_sel_s[bus.ReadRegister1]) begin
      rd1_s = bus.WriteData;
      rv1_s = 1'b1;
    end else begin
      rd1_s = regs_r[bus.ReadRegister1];
      rv1_s = valid_r[bus.ReadRegister1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2_s = '0;
    rv2_s = 1'b1;
    if (bus.ReadRegister2 == 5'd0) begin
      rd2_s = '0;
      rv2_s = 1'b1;
    end else if (BypassEn && wr_sel_s[bus.ReadRegister2]) begin
      rd2_s = bus.WriteData;
      rv2_s = 1'b1;
    end else begin
      rd2_s = regs_r[bus.ReadRegister2];
      rv2_s = valid_r[bus.ReadRegister2];
    end
  end

  assign bus.ReadData1  = rd1_s;
  assign bus.ReadData2  = rd2_s;
  assign bus.ReadValid1 = rv1_s;
  assign bus.ReadValid2 = rv2_s;
  assign bus.WriteCount = cnt_r;

endmodule

// File: tb/tb_regfile_rst.sv
// Scoreboard bench for regfile_rst: a no-bypass 16-bit-counter instance and a
// bypass 4-bit-counter instance share stimulus and are checked against one model.
module tb_regfile_rst;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  regfile_rst_if #(.WIDTH(32), .CNTW(16)) bus0 ();
  regfile_rst_if #(.WIDTH(32), .CNTW(4))  bus1 ();

  regfile_rst #(.WIDTH(32), .BYPASS(0), .CNTW(16)) dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0.slave));
  regfile_rst #(.WIDTH(32), .BYPASS(1), .CNTW(4))  dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1.slave));

  typedef struct {
    int          tag;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] cnt;
  } exp_t;

  logic [31:0] m_regs [32];
  bit          m_valid [32];
  int unsigned m_cnt;
  bit          known;
  int          tag;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0;
  exp_t        e1;
  int          n_checks;
  int          n_fail;

  function automatic void check(input string nm, input int t, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s tag=%0d actual=%h required=%h", nm, t, act, req);
    end
  endfunction

  // Reference view of one read port before the coming edge.
  function automatic void model_read(input bit byp, input bit live, input logic [4:0] wa,
                                     input logic [31:0] wd, input logic [4:0] ra,
                                     output logic [31:0] d, output logic [31:0] v);
    if (ra == 5'd0) begin
      d = 32'd0; v = 32'd1;
    end else if (byp && live && (wa == ra)) begin
      d = wd; v = 32'd1;
    end else begin
      d = m_regs[ra]; v = {31'd0, m_valid[ra]};
    end
  endfunction

  task automatic cycle(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    exp_t a;
    exp_t b;
    bit live;
    Reset = rst;
    bus0.RegWrite = we; bus0.WriteRegister = wa; bus0.WriteData = wd;
    bus0.ReadRegister1 = r1; bus0.ReadRegister2 = r2;
    bus1.RegWrite = we; bus1.WriteRegister = wa; bus1.WriteData = wd;
    bus1.ReadRegister1 = r1; bus1.ReadRegister2 = r2;
    live = we && !rst && (wa != 5'd0);
    if (known) begin
      tag++;
      a.tag = tag; b.tag = tag;
      model_read(1'b0, live, wa, wd, r1, a.d1, a.v1);
      model_read(1'b0, live, wa, wd, r2, a.d2, a.v2);
      model_read(1'b1, live, wa, wd, r1, b.d1, b.v1);
      model_read(1'b1, live, wa, wd, r2, b.d2, b.v2);
      a.cnt = m_cnt % 32'd65536;
      b.cnt = m_cnt % 32'd16;
      q0.push_back(a);
      q1.push_back(b);
    end
    @(posedge Clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_valid[i] = 1'b0;
      end
      m_cnt = 0;
      known = 1'b1;
    end else if (live) begin
      m_regs[wa] = wd;
      m_valid[wa] = 1'b1;
      m_cnt++;
    end
    #1;
  endtask

  // Monitor: compare whatever expectation is pending against the live outputs.
  always @(negedge Clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      check("nobyp_rd1", e0.tag, bus0.ReadData1, e0.d1);
      check("nobyp_rd2", e0.tag, bus0.ReadData2, e0.d2);
      check("nobyp_rv1", e0.tag, {31'd0, bus0.ReadValid1}, e0.v1);
      check("nobyp_rv2", e0.tag, {31'd0, bus0.ReadValid2}, e0.v2);
      check("nobyp_cnt", e0.tag, {16'd0, bus0.WriteCount}, e0.cnt);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check("byp_rd1", e1.tag, bus1.ReadData1, e1.d1);
      check("byp_rd2", e1.tag, bus1.ReadData2, e1.d2);
      check("byp_rv1", e1.tag, {31'd0, bus1.ReadValid1}, e1.v1);
      check("byp_rv2", e1.tag, {31'd0, bus1.ReadValid2}, e1.v2);
      check("byp_cnt", e1.tag, {28'd0, bus1.WriteCount}, e1.cnt);
    end
  end

  initial begin
    logic [4:0] wa;
    logic [4:0] r1;
    logic [4:0] r2;
    n_checks = 0; n_fail = 0; known = 1'b0; m_cnt = 0; tag = 0;

    // reset, then read r2/r31 cleared
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd2, 5'd31);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd31);
    // r2 <= 42, then 15
    cycle(1'b0, 1'b1, 5'd2, 32'd42, 5'd2, 5'd2);
    cycle(1'b0, 1'b1, 5'd2, 32'd15, 5'd2, 5'd2);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd2);
    // write to r0 ignored
    cycle(1'b0, 1'b1, 5'd0, 32'd25, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    // RegWrite low ignored
    cycle(1'b0, 1'b0, 5'd3, 32'd34, 5'd3, 5'd3);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    // decoder sweep
    for (int i = 1; i < 32; i++) cycle(1'b0, 1'b1, 5'(i), 32'(i + 100), 5'(i), 5'(32 - i));
    for (int i = 1; i < 32; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i));
    cycle(1'b0, 1'b1, 5'd4, 32'd555, 5'd1, 5'd4);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd4);
    // reset beats a simultaneous write
    cycle(1'b0, 1'b1, 5'd5, 32'd7, 5'd5, 5'd5);
    cycle(1'b1, 1'b1, 5'd5, 32'd9, 5'd5, 5'd5);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    // un-clocked write visible only through the bypass
    cycle(1'b0, 1'b1, 5'd6, 32'd9, 5'd6, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd6, 5'd6);

    for (int n = 0; n < 600; n++) begin
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, wa, 32'($urandom), r1, r2);
    end

    for (int k = 0; k < 10 && (q0.size() > 0 || q1.size() > 0); k++) @(posedge Clk);
    n_checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
